result_digit_emitter: RTL and testbench
=======================================

# result_digit_emitter

Converts a 32-bit unsigned calculator result back into a stream of decimal digits for the display path. It is the inverse of the digit-entry accumulator, which builds a value as `value*10 + digit`. This block decomposes the value with a sequential double-dabble conversion. It then hands out one BCD digit per transfer with its decimal position on a valid/ready handshake toward the display control.

## Interface
Parameters:
- none (width fixed at 32 bits, 10 decimal digits)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  request conversion of `value`; sampled only in IDLE
- value  in  32  unsigned result to convert; captured on accepted start
- digit_ready  in  1  display side accepts current digit
- digit_valid  out  1  `data`/`position` hold a valid digit
- data  out  4  BCD digit, 0..9
- position  out  4  decimal weight index, 0 = units, 9 = 10^9
- status  out  2  00 IDLE, 01 CONVERT, 10 EMIT, 11 DONE
- busy  out  1  high whenever status != 00

## Operation
- IDLE: status=00, busy=0, digit_valid=0, data=0, position=0. If start=1, the block captures value into a 32-bit shift register, clears a 40-bit BCD register and the bit counter, and moves to CONVERT.
- CONVERT: runs 32 double-dabble iterations, one per cycle. Each iteration:
  - adds 3 to every BCD nibble that is ≥5;
  - then shifts {bcd, bin} left by 1.
  After iteration 32 the block computes the digit count n and goes to EMIT with position=0.
- Digit count n:
  - without the macro, n = 10;
  - with the macro, n = 1 + index of the most significant nonzero nibble, or 1 if the value is 0.
- EMIT:
  - digit_valid=1, data = BCD nibble[position], position counts 0→n-1 (LS digit first).
  - A transfer occurs on a cycle with digit_valid & digit_ready. The block then increments position.
  - After the transfer at position n-1 it moves to DONE.
- DONE: one cycle, status=11, digit_valid=0, then IDLE.
- start outside IDLE is ignored; value is not re-captured.
- data/position are driven only from registers, never combinationally from digit_ready.
- BCD nibbles never exceed 9 after conversion. The maximum value 4294967295 fits in 10 digits. No overflow state exists.

## Timing
- Reset value of every output is 0 (digit_valid, data, position, status, busy). State goes to IDLE, registers are cleared.
- Reset mid-CONVERT or mid-EMIT aborts the operation with no DONE. The first start after reset deasserts is accepted normally.
- Start accepted at edge 0 gives:
  - status=01 for cycles 1..32;
  - first digit_valid in cycle 33.
- With digit_ready held high, one digit transfers per cycle:
  - without the macro: digits in cycles 33..42, DONE in cycle 43, IDLE in cycle 44;
  - in general: DONE in cycle 33+n, IDLE in cycle 34+n.
- A new start may be sampled in the first IDLE cycle, i.e. back-to-back operations have a one-cycle IDLE gap.
- Backpressure: while digit_ready=0, digit_valid, data and position stay stable. Throughput resumes on the cycle ready returns.
- digit_ready is ignored outside EMIT.

## Configuration
- Macro `LEADING_ZERO_BLANK_EN`.
  - Defined: leading zeros are not emitted. n is the count of significant digits (1..10), and a value of 0 emits a single digit 0 at position 0.
  - Undefined: all 10 digits are always emitted, including leading zeros. The nonzero-detect logic is absent.
- Conversion latency (32 cycles) is identical in both builds.

## Test plan
- Reset check: assert reset mid-cycle with arbitrary inputs -> all outputs 0 asynchronously, status=00 after release.
- Without macro, value=1234, ready=1:
  - data 4,3,2,1,0,0,0,0,0,0 at positions 0..9, cycles 33..42;
  - status=11 in cycle 43, 00 in cycle 44.
- With `LEADING_ZERO_BLANK_EN`:
  - value=1234 -> 4,3,2,1 at positions 0..3, DONE in cycle 37;
  - value=0 -> single digit 0 at position 0, DONE in cycle 34.
- Max value 0xFFFFFFFF -> data 5,9,2,7,6,9,4,9,2,4 at positions 0..9 (either build).
- Backpressure with value=1234: ready=0 in cycles 33..35 -> data=4, position=0, digit_valid=1 held stable; the digit transfers in cycle 36 and the remaining digits follow one per cycle.
- Busy/abort:
  - start pulse with value=99 during CONVERT -> ignored, the original value is emitted;
  - reset asserted in cycle 20 -> outputs 0 immediately, no digits emitted, DONE never seen.

Source files
------------

// File: rtl/result_digit_emitter.sv
// result_digit_emitter: 32-bit binary to BCD (sequential double-dabble), digits streamed LS-first on valid/ready.
// Define LEADING_ZERO_BLANK_EN to stop after the most significant nonzero digit instead of emitting all 10.
module result_digit_emitter (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    input  logic        digit_ready,
    output logic        digit_valid,
    output logic [3:0]  data,
    output logic [3:0]  position,
    output logic [1:0]  status,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE = 2'b00, CONVERT = 2'b01, EMIT = 2'b10, DONE = 2'b11} state_t;
    state_t      state_q;
    logic [31:0] bin_q, bin_d;
    logic [39:0] bcd_q, bcd_d, adj;
    logic [4:0]  cnt_q;
    logic [3:0]  pos_q, last_q, last_d;
    always_comb begin
        for (int i = 0; i < 10; i++)
            adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
        {bcd_d, bin_d} = {adj[38:0], bin_q, 1'b0};
`ifdef LEADING_ZERO_BLANK_EN
        last_d = 4'd0;
        for (int i = 1; i < 10; i++)
            if (bcd_d[4*i+:4] != 4'd0) last_d = 4'(i);
`else
        last_d = 4'd9;
`endif
    end
    // Emitted digits are shifted out of the bottom of bcd_q, so the current digit is always nibble 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
            last_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    bin_q   <= value;
                    bcd_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= CONVERT;
                end
                CONVERT: begin
                    bin_q <= bin_d;
                    bcd_q <= bcd_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        pos_q   <= '0;
                        last_q  <= last_d;
                        state_q <= EMIT;
                    end
                end
                EMIT: if (digit_ready) begin
                    if (pos_q == last_q) begin
                        pos_q   <= '0;
                        bcd_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        pos_q <= pos_q + 4'd1;
                        bcd_q <= {4'd0, bcd_q[39:4]};
                    end
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end
    assign status      = state_q;
    assign busy        = state_q != IDLE;
    assign digit_valid = state_q == EMIT;
    assign data        = digit_valid ? bcd_q[3:0] : 4'd0;
    assign position    = pos_q;
endmodule

// File: tb/tb_result_digit_emitter.sv
// tb_result_digit_emitter: directed vectors with hand-computed BCD expectations plus reset/abort sequences.
module tb_result_digit_emitter;
    logic        clock = 1'b0, reset = 1'b1, start = 1'b0, digit_ready = 1'b1;
    logic [31:0] value = '0;
    logic        digit_valid, busy;
    logic [3:0]  data, position;
    logic [1:0]  status;
    int tests = 0, fails = 0;

    typedef struct {
        logic [31:0] v;
        logic [39:0] bcd;
        int          sig;
        int          stall;
        bit          poke;
    } vec_t;
    vec_t vecs[9];

    result_digit_emitter dut (
        .clock(clock), .reset(reset), .start(start), .value(value), .digit_ready(digit_ready),
        .digit_valid(digit_valid), .data(data), .position(position), .status(status), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input vec_t t);
        int n;
        logic [39:0] b;
`ifdef LEADING_ZERO_BLANK_EN
        n = t.sig;
`else
        n = 10;
`endif
        b = t.bcd;
        @(negedge clock);
        start = 1'b1;
        value = t.v;
        digit_ready = (t.stall == 0);
        @(negedge clock);
        start = 1'b0;
        chk("status_cycle1", int'(status), 1);
        chk("busy_cycle1", int'(busy), 1);
        for (int c = 2; c <= 32; c++) begin
            @(negedge clock);
            if (t.poke && c == 10) begin
                start = 1'b1;
                value = 32'd99;
            end
            if (c == 11) start = 1'b0;
        end
        chk("status_cycle32", int'(status), 1);
        chk("valid_cycle32", int'(digit_valid), 0);
        for (int j = 0; j < t.stall; j++) begin
            @(negedge clock);
            chk("stall_valid", int'(digit_valid), 1);
            chk("stall_data", int'(data), int'(b[3:0]));
            chk("stall_position", int'(position), 0);
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            digit_ready = 1'b1;
            chk("digit_valid", int'(digit_valid), 1);
            chk("digit_data", int'(data), int'(b[4*k+:4]));
            chk("digit_position", int'(position), k);
        end
        @(negedge clock);
        chk("status_done", int'(status), 3);
        chk("valid_done", int'(digit_valid), 0);
        @(negedge clock);
        chk("status_idle", int'(status), 0);
        chk("busy_idle", int'(busy), 0);
        chk("data_idle", int'(data), 0);
    endtask

    initial begin
        int seen_valid, seen_done;
        vecs[0] = '{32'd1234,       40'h0000001234, 4,  0, 1'b0};
        vecs[1] = '{32'd0,          40'h0000000000, 1,  0, 1'b0};
        vecs[2] = '{32'd4294967295, 40'h4294967295, 10, 0, 1'b0};
        vecs[3] = '{32'd1000000000, 40'h1000000000, 10, 0, 1'b0};
        vecs[4] = '{32'd7,          40'h0000000007, 1,  0, 1'b0};
        vecs[5] = '{32'd90817,      40'h0000090817, 5,  0, 1'b0};
        vecs[6] = '{32'd59,         40'h0000000059, 2,  0, 1'b0};
        vecs[7] = '{32'd1234,       40'h0000001234, 4,  3, 1'b0};
        vecs[8] = '{32'd1234,       40'h0000001234, 4,  0, 1'b1};

        start = 1'b1;
        value = 32'hDEAD_BEEF;
        #12;
        chk("reset_valid", int'(digit_valid), 0);
        chk("reset_data", int'(data), 0);
        chk("reset_position", int'(position), 0);
        chk("reset_status", int'(status), 0);
        chk("reset_busy", int'(busy), 0);
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        chk("status_after_reset", int'(status), 0);

        for (int i = 0; i < 9; i++) run(vecs[i]);

        @(negedge clock);
        start = 1'b1;
        value = 32'd1234;
        digit_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (19) @(negedge clock);
        chk("abort_status_before", int'(status), 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_status", int'(status), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(digit_valid), 0);
        @(negedge clock);
        reset = 1'b0;
        seen_valid = 0;
        seen_done = 0;
        repeat (50) begin
            @(negedge clock);
            if (digit_valid) seen_valid++;
            if (status == 2'b11) seen_done++;
        end
        chk("abort_no_digits", seen_valid, 0);
        chk("abort_no_done", seen_done, 0);
        run(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
